// File: rtl/muldiv_seq_pkg.sv
// Shared widths, opcodes and ALU function codes for the ONC-16 multiply/divide unit.
package muldiv_seq_pkg;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned ALU_FUNC_W = 3;
   localparam int unsigned FR_FLAG_W  = 1;
   localparam int unsigned FR_C       = 0;
   localparam int unsigned CNT_W      = 4;

   localparam logic [CNT_W-1:0] CNT_LAST = '1;

   typedef enum logic [ALU_FUNC_W-1:0] {
      ALU_ADD   = 3'd0,
      ALU_SUB   = 3'd1,
      ALU_AND   = 3'd2,
      ALU_OR    = 3'd3,
      ALU_XOR   = 3'd4,
      ALU_PASSB = 3'd5
   } alu_func_e;

   typedef enum logic {
      MD_MULU = 1'b0,
      MD_DIVU = 1'b1
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/muldiv_seq_alu.sv
// Combinational ALU; C flag is carry-out for ADD and unsigned borrow (a < b) for SUB.
module muldiv_seq_alu
   import muldiv_seq_pkg::*;
(
   input  logic [DATA_W-1:0]    a,
   input  logic [DATA_W-1:0]    b,
   input  alu_func_e            func,
   output logic [DATA_W-1:0]    y_c,
   output logic [FR_FLAG_W-1:0] flags_c
);

   logic [DATA_W:0] ext;

   always_comb begin
      ext     = '0;
      y_c     = '0;
      flags_c = '0;
      case (func)
         ALU_ADD: begin
            ext           = {1'b0, a} + {1'b0, b};
            y_c           = ext[DATA_W-1:0];
            flags_c[FR_C] = ext[DATA_W];
         end
         ALU_SUB: begin
            ext           = {1'b0, a} - {1'b0, b};
            y_c           = ext[DATA_W-1:0];
            flags_c[FR_C] = ext[DATA_W];
         end
         ALU_AND:   y_c = a & b;
         ALU_OR:    y_c = a | b;
         ALU_XOR:   y_c = a ^ b;
         ALU_PASSB: y_c = b;
         default:   y_c = a;
      endcase
   end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned 16x16 multiply (shift-and-add) and 16/16 divide (restoring),
// one ALU step per clock through a private ALU instance.
module muldiv_seq
   import muldiv_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              op,
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] res_hi,
   output logic [DATA_W-1:0] res_lo,
   output logic              dz
);

   md_state_e             state, state_d;
   md_op_e                op_q;
   logic [DATA_W-1:0]     hi, lo, b_q;
   logic [DATA_W-1:0]     hi_d, lo_d;
   logic [CNT_W-1:0]      cnt;
   logic                  busy_d, done_d;
   logic                  accept, dz_start;

   logic [DATA_W-1:0]     alu_a, alu_b, alu_y;
   alu_func_e             alu_func;
   logic [FR_FLAG_W-1:0]  alu_flags;
   logic [DATA_W-1:0]     div_a;

   assign accept   = (state == S_IDLE) && start;
   assign dz_start = (op == MD_DIVU) && (opb == '0);
   assign div_a    = {hi[DATA_W-2:0], lo[DATA_W-1]};
   assign res_hi   = hi;
   assign res_lo   = lo;

   muldiv_seq_alu u_alu (
      .a       (alu_a),
      .b       (alu_b),
      .func    (alu_func),
      .y_c     (alu_y),
      .flags_c (alu_flags)
   );

   // ALU operand select; held at ADD with zero operands outside RUN so flags stay quiet
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_func = ALU_ADD;
      if (state == S_RUN) begin
         if (op_q == MD_MULU) begin
            alu_a    = hi;
            alu_b    = lo[0] ? b_q : '0;
            alu_func = ALU_ADD;
         end else begin
            alu_a    = div_a;
            alu_b    = b_q;
            alu_func = ALU_SUB;
         end
      end
   end

   // Next state, next datapath values and registered output precursors
   always_comb begin
      state_d = state;
      hi_d    = hi;
      lo_d    = lo;
      case (state)
         S_IDLE: begin
            if (start) state_d = dz_start ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (op_q == MD_MULU) begin
               {hi_d, lo_d} = {alu_flags[FR_C], alu_y, lo[DATA_W-1:1]};
            end else if (hi[DATA_W-1] | ~alu_flags[FR_C]) begin
               hi_d = alu_y;
               lo_d = {lo[DATA_W-2:0], 1'b1};
            end else begin
               hi_d = div_a;
               lo_d = {lo[DATA_W-2:0], 1'b0};
            end
            if (cnt == CNT_LAST) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

   // Datapath registers; a divide by zero loads the final result directly on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         hi   <= '0;
         lo   <= '0;
         b_q  <= '0;
         cnt  <= '0;
         op_q <= MD_MULU;
         dz   <= 1'b0;
      end else if (accept) begin
         hi   <= dz_start ? opa : '0;
         lo   <= dz_start ? '1 : opa;
         b_q  <= opb;
         cnt  <= '0;
         op_q <= md_op_e'(op);
         dz   <= dz_start;
      end else if (state == S_RUN) begin
         hi   <= hi_d;
         lo   <= lo_d;
         cnt  <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq: latency, busy window, results, dz, abort and ignored starts.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst, start, op;
   logic [15:0] opa, opb;
   logic        busy, done, dz;
   logic [15:0] res_hi, res_lo;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [15:0] hi;
      logic [15:0] lo;
      logic        dz;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   muldiv_seq dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .opa    (opa),
      .opb    (opb),
      .busy   (busy),
      .done   (done),
      .res_hi (res_hi),
      .res_lo (res_lo),
      .dz     (dz)
   );

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic o, input logic [15:0] a, input logic [15:0] d);
      exp_t r;
      logic [31:0] p;
      if (!o) begin
         p    = 32'(a) * 32'(d);
         r.hi = p[31:16];
         r.lo = p[15:0];
         r.dz = 1'b0;
      end else if (d == 16'h0000) begin
         r.hi = a;
         r.lo = 16'hFFFF;
         r.dz = 1'b1;
      end else begin
         r.hi = a % d;
         r.lo = a / d;
         r.dz = 1'b0;
      end
      return r;
   endfunction

   // Issue one op, optionally pulse start at cycle ign while busy, then score the result
   task automatic do_op(input string tag, input logic o, input logic [15:0] a,
                        input logic [15:0] d, input int ign);
      exp_t e, got;
      int   done_at, done_cnt, busy_cnt, exp_lat;
      exp_lat = (o && d == 16'h0000) ? 1 : 17;
      @(negedge clk);
      start = 1'b1; op = o; opa = a; opb = d;
      sb.push_back(model(o, a, d));
      done_at = 0; done_cnt = 0; busy_cnt = 0; got = '0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start = 1'b0; op = ~o; opa = 16'hDEAD; opb = 16'h0000;
         end
         if (ign != 0 && n == ign) begin
            start = 1'b1; op = 1'b1; opa = 16'h5A5A; opb = 16'h0000;
         end
         if (ign != 0 && n == ign + 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at == 0) begin
               done_at = n;
               got     = {res_hi, res_lo, dz};
            end
         end
         if (!busy) break;
      end
      start = 1'b0;
      check({tag, ".latency"}, 32'(done_at), 32'(exp_lat));
      check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
      check({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, ".sb_pending"}, 32'(sb.size() != 0), 32'd1);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      check({tag, ".res_hi"}, 32'(got.hi), 32'(e.hi));
      check({tag, ".res_lo"}, 32'(got.lo), 32'(e.lo));
      check({tag, ".dz"}, 32'(got.dz), 32'(e.dz));
      @(negedge clk);
      check({tag, ".held"}, {res_hi, res_lo}, {e.hi, e.lo});
   endtask

   initial begin
      int dcnt;
      rst = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
      repeat (2) @(negedge clk);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      check("reset.dz", 32'(dz), 32'd0);
      check("reset.res", {res_hi, res_lo}, 32'd0);

      // reset and start together: request dropped
      start = 1'b1; op = 1'b0; opa = 16'h0003; opb = 16'h0003;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst_start.busy", 32'(busy), 32'd0);
      check("rst_start.done", 32'(done), 32'd0);

      do_op("mul_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 0);
      do_op("mul_1234", 1'b0, 16'h1234, 16'h0010, 0);
      do_op("mul_zero", 1'b0, 16'h0000, 16'hFFFF, 0);
      do_op("div_eeee", 1'b1, 16'hEEEE, 16'h000F, 0);
      do_op("div_by1", 1'b1, 16'hFFFF, 16'h0001, 0);
      do_op("div_small", 1'b1, 16'h0001, 16'hFFFF, 0);
      do_op("div_t1", 1'b1, 16'hFFFF, 16'h8001, 0);
      do_op("div_zero", 1'b1, 16'h8000, 16'h0000, 0);
      repeat (3) @(negedge clk);
      check("dz_hold", 32'(dz), 32'd1);
      do_op("mul_after_dz", 1'b0, 16'h0003, 16'h0005, 0);

      // abort mid-run with reset
      @(negedge clk);
      start = 1'b1; op = 1'b0; opa = 16'hFFFF; opb = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.done", 32'(done), 32'd0);
      check("abort.dz", 32'(dz), 32'd0);
      check("abort.res", {res_hi, res_lo}, 32'd0);
      dcnt = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("abort.no_done", 32'(dcnt), 32'd0);

      do_op("mul_ign", 1'b0, 16'h00FF, 16'h0101, 5);
      do_op("div_ign", 1'b1, 16'h1234, 16'h0007, 6);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
